// File: rtl/maxpool_stream_pkg.sv
// Shared defaults and helpers for the streaming max-pool stage.
// Imported by the lane comparator and the top level.
package maxpool_stream_pkg;

    localparam int unsigned DefaultDataBits = 8;
    localparam int unsigned DefaultC        = 6;
    localparam int unsigned DefaultW        = 24;
    localparam int unsigned DefaultH        = 24;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool_stream_max.sv
// Combinational lane-wise max of two packed C-lane vectors.
// SIGNED selects two's-complement or unsigned compare per lane.
module pool_max_c
    import maxpool_stream_pkg::*;
#(
    parameter int unsigned DATA_BITS = DefaultDataBits,
    parameter int unsigned C         = DefaultC,
    parameter bit          SIGNED    = 1'b1
) (
    input  logic [C*DATA_BITS-1:0] a,
    input  logic [C*DATA_BITS-1:0] b,
    output logic [C*DATA_BITS-1:0] y
);

    for (genvar k = 0; k < C; k++) begin : g_lane
        logic [DATA_BITS-1:0] la;
        logic [DATA_BITS-1:0] lb;
        logic                 a_wins;

        assign la = a[k*DATA_BITS +: DATA_BITS];
        assign lb = b[k*DATA_BITS +: DATA_BITS];

        if (SIGNED) begin : g_signed
            assign a_wins = $signed(la) >= $signed(lb);
        end else begin : g_unsigned
            assign a_wins = la >= lb;
        end

        assign y[k*DATA_BITS +: DATA_BITS] = a_wins ? la : lb;
    end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max-pooling stage with valid/ready on both sides
// and optional fused ReLU.
module maxpool_stream
    import maxpool_stream_pkg::*;
#(
    parameter int unsigned DATA_BITS = DefaultDataBits,
    parameter int unsigned C         = DefaultC,
    parameter int unsigned W         = DefaultW,
    parameter int unsigned H         = DefaultH,
    parameter bit          SIGNED    = 1'b1,
    parameter bit          RELU      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [C*DATA_BITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [C*DATA_BITS-1:0] out_data,
    output logic                   out_last
);

    localparam int unsigned DW       = C * DATA_BITS;
    localparam int unsigned ColBits  = idx_bits(W);
    localparam int unsigned RowBits  = idx_bits(H);
    localparam int unsigned BufDepth = W / 2;
    localparam int unsigned BufBits  = idx_bits(BufDepth);
    localparam logic [ColBits-1:0] ColMax = ColBits'(W - 1);
    localparam logic [RowBits-1:0] RowMax = RowBits'(H - 1);

    if ((W % 2) != 0 || W < 2) begin : g_bad_w
        $error("maxpool_stream: W must be even and non-zero");
    end
    if ((H % 2) != 0 || H < 2) begin : g_bad_h
        $error("maxpool_stream: H must be even and non-zero");
    end

    logic [ColBits-1:0] col;
    logic [RowBits-1:0] row;
    logic [DW-1:0]      hold;
    logic [DW-1:0]      rowbuf [BufDepth];
    logic [BufBits-1:0] buf_idx;
    logic [DW-1:0]      rowbuf_rd;
    logic [DW-1:0]      pair_max;
    logic [DW-1:0]      win_max;
    logic [DW-1:0]      result;
    logic               accept;
    logic               col_last;
    logic               row_last;

    assign in_ready  = !reset && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign col_last  = (col == ColMax);
    assign row_last  = (row == RowMax);
    assign buf_idx   = BufBits'(col >> 1);
    assign rowbuf_rd = rowbuf[buf_idx];

    pool_max_c #(
        .DATA_BITS (DATA_BITS),
        .C         (C),
        .SIGNED    (SIGNED)
    ) u_pair_max (
        .a (hold),
        .b (in_data),
        .y (pair_max)
    );

    pool_max_c #(
        .DATA_BITS (DATA_BITS),
        .C         (C),
        .SIGNED    (SIGNED)
    ) u_win_max (
        .a (rowbuf_rd),
        .b (pair_max),
        .y (win_max)
    );

    // ReLU only has meaning for two's-complement lanes.
    always_comb begin
        result = win_max;
        if (SIGNED && RELU) begin
            for (int k = 0; k < int'(C); k++) begin
                if (win_max[k*DATA_BITS + DATA_BITS - 1]) begin
                    result[k*DATA_BITS +: DATA_BITS] = '0;
                end
            end
        end
    end

    // Even rows deposit the horizontal pair max; odd rows read it back.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            rowbuf[buf_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    hold <= in_data;
                end else if (row[0]) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    out_last  <= row_last && col_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: small unsigned/signed frames plus a
// default-size frame against a reference max-pool model.
module tb_maxpool_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4x4, C=1, unsigned
    logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_last;
    logic [7:0] u_in_data, u_out_data;
    // 2x2, C=2, signed, with and without ReLU (shared input)
    logic        rn_in_valid, r_in_ready, n_in_ready;
    logic [15:0] rn_in_data, r_out_data, n_out_data;
    logic        r_out_valid, r_out_last, n_out_valid, n_out_last;
    // Default parameters
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_last;
    logic [47:0] d_in_data, d_out_data;

    maxpool_stream #(
        .DATA_BITS (8), .C (1), .W (4), .H (4), .SIGNED (1'b0), .RELU (1'b0)
    ) dut_u (
        .clk (clk), .reset (reset),
        .in_valid (u_in_valid), .in_ready (u_in_ready), .in_data (u_in_data),
        .out_valid (u_out_valid), .out_ready (u_out_ready),
        .out_data (u_out_data), .out_last (u_out_last)
    );

    maxpool_stream #(
        .DATA_BITS (8), .C (2), .W (2), .H (2), .SIGNED (1'b1), .RELU (1'b1)
    ) dut_r (
        .clk (clk), .reset (reset),
        .in_valid (rn_in_valid), .in_ready (r_in_ready), .in_data (rn_in_data),
        .out_valid (r_out_valid), .out_ready (1'b1),
        .out_data (r_out_data), .out_last (r_out_last)
    );

    maxpool_stream #(
        .DATA_BITS (8), .C (2), .W (2), .H (2), .SIGNED (1'b1), .RELU (1'b0)
    ) dut_n (
        .clk (clk), .reset (reset),
        .in_valid (rn_in_valid), .in_ready (n_in_ready), .in_data (rn_in_data),
        .out_valid (n_out_valid), .out_ready (1'b1),
        .out_data (n_out_data), .out_last (n_out_last)
    );

    maxpool_stream dut_d (
        .clk (clk), .reset (reset),
        .in_valid (d_in_valid), .in_ready (d_in_ready), .in_data (d_in_data),
        .out_valid (d_out_valid), .out_ready (1'b1),
        .out_data (d_out_data), .out_last (d_out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output transfers captured from dut_u, plus stall bookkeeping.
    logic [7:0] q_data[$];
    logic       q_last[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic       stall_last;
    logic       par = 1'b0;

    task automatic u_cycle(input logic v, input logic [7:0] d, input logic rdy,
                           output logic acc);
        @(negedge clk);
        u_in_valid  = v;
        u_in_data   = d;
        u_out_ready = rdy;
        #1;
        acc = v && u_in_ready;
        if (stall_prev) begin
            check("stall_valid_held", 64'(u_out_valid), 64'(1));
            check("stall_data_held", 64'(u_out_data), 64'(stall_data));
            check("stall_last_held", 64'(u_out_last), 64'(stall_last));
        end
        if (u_out_valid && !u_out_ready) begin
            check("stall_in_ready_low", 64'(u_in_ready), 64'(0));
            stall_prev = 1'b1;
            stall_data = u_out_data;
            stall_last = u_out_last;
        end else begin
            stall_prev = 1'b0;
        end
        if (u_out_valid && u_out_ready) begin
            q_data.push_back(u_out_data);
            q_last.push_back(u_out_last);
        end
    endtask

    task automatic u_send_frame(input int base, input bit rev, input bit toggle, input int npix);
        logic acc;
        int   tries;
        for (int i = 0; i < npix; i++) begin
            tries = 0;
            do begin
                par = ~par;
                u_cycle(1'b1, 8'(rev ? base + 15 - i : base + i), toggle ? par : 1'b1, acc);
                tries++;
            end while (!acc && tries < 8);
            if (!acc) check($sformatf("accept_timeout_px%0d", i), 64'(acc), 64'(1));
        end
    endtask

    task automatic u_drain(input int n, input bit toggle);
        logic acc;
        for (int i = 0; i < n; i++) begin
            par = ~par;
            u_cycle(1'b0, 8'h00, toggle ? par : 1'b1, acc);
        end
    endtask

    task automatic check_frame(input string tag, input int off,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] ev [4];
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            if (off + k < q_data.size()) begin
                check($sformatf("%s_data%0d", tag, k), 64'(q_data[off+k]), 64'(ev[k]));
                check($sformatf("%s_last%0d", tag, k), 64'(q_last[off+k]), 64'(k == 3));
            end
        end
    endtask

    function automatic logic [47:0] lmax(input logic [47:0] a, input logic [47:0] b);
        logic [47:0] y;
        logic [7:0]  la, lb;
        for (int l = 0; l < 6; l++) begin
            la = a[l*8 +: 8];
            lb = b[l*8 +: 8];
            y[l*8 +: 8] = ($signed(la) > $signed(lb)) ? la : lb;
        end
        return y;
    endfunction

    logic [47:0] pix [576];
    logic [47:0] expd [144];
    logic [15:0] rpix [4];

    initial begin
        int n_out, last_idx, last_cnt, stalls, base;

        reset = 1'b1;
        u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
        rn_in_valid = 1'b0; rn_in_data = '0;
        d_in_valid = 1'b0; d_in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(u_in_ready), 64'(0));
        check("rst_out_valid", 64'(u_out_valid), 64'(0));
        check("rst_out_data", 64'(u_out_data), 64'(0));
        check("rst_out_last", 64'(u_out_last), 64'(0));
        check("rst_d_out_data", 64'(d_out_data), 64'(0));
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(u_in_ready), 64'(1));

        // Test 1: 0..15 at full rate
        q_data.delete(); q_last.delete();
        u_send_frame(0, 1'b0, 1'b0, 16);
        u_drain(4, 1'b0);
        check("t1_count", 64'(q_data.size()), 64'(4));
        check_frame("t1", 0, 8'd5, 8'd7, 8'd13, 8'd15);

        // Test 2: out_ready toggling every cycle
        q_data.delete(); q_last.delete();
        u_send_frame(0, 1'b0, 1'b1, 16);
        u_drain(8, 1'b1);
        u_drain(2, 1'b0);
        check("t2_count", 64'(q_data.size()), 64'(4));
        check_frame("t2", 0, 8'd5, 8'd7, 8'd13, 8'd15);

        // Test 4: two back-to-back frames, second one reversed
        q_data.delete(); q_last.delete();
        u_send_frame(0, 1'b0, 1'b0, 16);
        u_send_frame(0, 1'b1, 1'b0, 16);
        u_drain(4, 1'b0);
        check("t4_count", 64'(q_data.size()), 64'(8));
        check_frame("t4a", 0, 8'd5, 8'd7, 8'd13, 8'd15);
        check_frame("t4b", 4, 8'd15, 8'd13, 8'd7, 8'd5);

        // Test 5: abort after pixel 9, then a fresh frame of 100+i
        u_send_frame(0, 1'b0, 1'b0, 10);
        @(negedge clk);
        u_in_valid = 1'b0;
        reset = 1'b1;
        stall_prev = 1'b0;
        @(negedge clk);
        check("t5_rst_out_valid", 64'(u_out_valid), 64'(0));
        check("t5_rst_in_ready", 64'(u_in_ready), 64'(0));
        reset = 1'b0;
        q_data.delete(); q_last.delete();
        u_send_frame(100, 1'b0, 1'b0, 16);
        u_drain(4, 1'b0);
        check("t5_count", 64'(q_data.size()), 64'(4));
        check_frame("t5", 0, 8'd105, 8'd107, 8'd113, 8'd115);

        // Test 3: signed window; lane1 = {-8,-1,-5,-2}, lane0 = -3
        rpix = '{16'hF8FD, 16'hFFFD, 16'hFBFD, 16'hFEFD};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) check("t3_no_early_valid", 64'(n_out_valid), 64'(0));
            rn_in_valid = 1'b1;
            rn_in_data  = rpix[k];
        end
        @(negedge clk);
        rn_in_valid = 1'b0;
        check("t3_relu_valid", 64'(r_out_valid), 64'(1));
        check("t3_relu_data", 64'(r_out_data), 64'(16'h0000));
        check("t3_relu_last", 64'(r_out_last), 64'(1));
        check("t3_norelu_valid", 64'(n_out_valid), 64'(1));
        check("t3_norelu_data", 64'(n_out_data), 64'(16'hFFFD));
        @(negedge clk);
        check("t3_valid_clears", 64'(n_out_valid), 64'(0));

        // Test 6: default 24x24, C=6 random frame against the model
        for (int i = 0; i < 576; i++) pix[i] = {16'($urandom), $urandom};
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                base = 2 * r * 24 + 2 * c;
                expd[r*12+c] = lmax(lmax(pix[base], pix[base+1]),
                                    lmax(pix[base+24], pix[base+25]));
            end
        end
        n_out = 0; last_idx = -1; last_cnt = 0; stalls = 0;
        for (int i = 0; i < 580; i++) begin
            @(negedge clk);
            if (d_out_valid) begin
                if (n_out < 144)
                    check($sformatf("t6_out%0d", n_out), 64'(d_out_data), 64'(expd[n_out]));
                if (d_out_last) begin
                    last_idx = n_out;
                    last_cnt++;
                end
                n_out++;
            end
            if (i < 576) begin
                if (!d_in_ready) stalls++;
                d_in_valid = 1'b1;
                d_in_data  = pix[i];
            end else begin
                d_in_valid = 1'b0;
            end
        end
        check("t6_count", 64'(n_out), 64'(144));
        check("t6_stalls", 64'(stalls), 64'(0));
        check("t6_last_idx", 64'(last_idx), 64'(143));
        check("t6_last_cnt", 64'(last_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
